// File: rtl/cpu_pkg.sv
// Shared CPU constants: data word width, stack opcodes and the default call stack depth.
package cpu_pkg;
  localparam int WORD_W      = 16;
  localparam int STACK_DEPTH = 16;

  // The decoder compares instr[14:9] against these to raise push/pop.
  localparam logic [5:0] OP_PSH = 6'b101000;
  localparam logic [5:0] OP_POP = 6'b101001;
endpackage

// File: rtl/call_stack_if.sv
// Decoder/ALU-facing bundle for the call stack: strobes, data in, and top-of-stack/status out.
interface call_stack_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = STACK_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             enable;
  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] stackout;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output enable, push, pop, clear, din,
    input  stackout, count, empty, full, overflow, underflow
  );

  modport slave (
    input  enable, push, pop, clear, din,
    output stackout, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack_stack_mem.sv
// Stack storage: synchronous-write, asynchronous-read register array with no reset.
module stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/call_stack.sv
// Hardware LIFO between the ALU result bus and the register file; owns the stack pointer,
// push/pop priority and the sticky overflow/underflow debug flags.
module call_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  call_stack_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

  logic [PTR_W:0]   sp;
  logic [PTR_W:0]   sp_dec;
  logic             is_empty;
  logic             is_full;
  logic             do_push;
  logic             do_pop;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [WIDTH-1:0] rd_data;
  logic             overflow_q;
  logic             underflow_q;

  assign sp_dec   = sp - ONE;
  assign is_empty = (sp == '0);
  assign is_full  = (sp == FULL_CNT);

  // enable is active low; reset and clear both swallow any strobe in their cycle.
  assign do_push = !reset && !bus.clear && !bus.enable && bus.push;
  assign do_pop  = !reset && !bus.clear && !bus.enable && bus.pop;

  // Push+pop on a non-empty stack rewrites the top in place; otherwise writes land at sp.
  assign wr_en   = do_push && (do_pop || !is_full);
  assign wr_addr = (do_pop && !is_empty) ? sp_dec[PTR_W-1:0] : sp[PTR_W-1:0];

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.din),
    .rd_addr (sp_dec[PTR_W-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      sp          <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (do_push && do_pop) begin
      if (is_empty) begin
        sp          <= ONE;
        underflow_q <= 1'b1;
      end
    end else if (do_push) begin
      if (is_full) overflow_q <= 1'b1;
      else         sp         <= sp + ONE;
    end else if (do_pop) begin
      if (is_empty) underflow_q <= 1'b1;
      else          sp          <= sp_dec;
    end
  end

  // Stale entries below an empty stack are never exposed.
  assign bus.stackout  = is_empty ? '0 : rd_data;
  assign bus.count     = sp;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware LIFO that sits directly downstream of the ALU for PSH and upstream of it for POP.
- On PSH, the ALU drives Rs1 onto its result bus and the decoder pulses push; the value is stored here.
- On POP, top-of-stack is presented combinationally on stackout, the ALU forwards it to the register file, and the decoder pulses pop to discard it.
- Also provides full/empty status and sticky overflow/underflow flags for debug.

Parameters:
- WIDTH, 16, data word width (matches register width).
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- PTR_W, $clog2(DEPTH), stack-pointer width; count uses PTR_W+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  active LOW; when high, push and pop are ignored (load/store phases).
- push  input  1  one-cycle strobe: write din to the new top.
- pop  input  1  one-cycle strobe: discard the current top.
- clear  input  1  synchronous flush; empties the stack and clears the sticky flags.
- din  input  WIDTH  value to push (ALU result bus).
- stackout  output  WIDTH  current top-of-stack; 0 when empty.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Storage: DEPTH x WIDTH register array, not reset. sp (PTR_W+1 bits) equals count; the top entry is mem[sp-1].
- Reset (reset=1 at a clock edge):
  - sp=0, overflow=0, underflow=0.
  - Hence stackout=0, count=0, empty=1, full=0.
  - reset has priority over clear, and clear over push/pop.
  - Reset in the same cycle as push or pop discards the operation.
- stackout is combinational from sp and mem: 0 if empty, else mem[sp-1]. It is valid in the same cycle as a pop strobe, so the ALU captures it before the edge.
- Gating: when enable=1, push and pop have no effect and no flags are set.
- Operation at the edge when enable=0 (one-cycle latency; the new state is visible the next cycle):
  - push only, not full: mem[sp]<=din; sp<=sp+1.
  - push only, full: no state change; overflow<=1. The top entry is never overwritten and sp never wraps.
  - pop only, not empty: sp<=sp-1; mem is unchanged.
  - pop only, empty: no change; underflow<=1. sp never goes negative.
  - push and pop, not empty: replace-top, mem[sp-1]<=din, sp unchanged. This is legal even when full; no flags set.
  - push and pop, empty: push performed (mem[0]<=din, sp<=1); underflow<=1.
- clear (reset=0): sp<=0, overflow<=0, underflow<=0; push and pop in that cycle are ignored. Stale mem contents are never visible, because stackout is forced to 0 when empty.
- Sticky flags stay set until reset or clear.
- Arithmetic: sp is unsigned, PTR_W+1 bits; the full-boundary compare is against DEPTH exactly. din is stored bit-exact (signedness is irrelevant).

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W=16.
  - Opcode constants OP_PSH=6'b101000 and OP_POP=6'b101001, used by the decoder to generate push/pop from instr[14:9].
  - STACK_DEPTH default.
- One sub-module, stack_mem: a synchronous-write, asynchronous-read register array (WIDTH, DEPTH, wr_en, wr_addr, wr_data, rd_addr, rd_data).
- call_stack owns the pointer, flags and priority logic.

Test Plan:
- Basic LIFO: after reset, push 16'h1234, then 16'hBEEF, then 16'h0007.
  - stackout = 0007, count=3.
  - pop: stackout=BEEF; pop: stackout=1234; pop: empty=1, stackout=0000.
- Overflow (DEPTH=16): push values 1..16 → full=1, stackout=16.
  - 17th push of 16'hFFFF → overflow=1, count=16, stackout still 16.
  - pop → stackout=15, full=0, overflow stays 1.
- Underflow: from empty, pop → underflow=1, count=0.
  - Then push 16'h00AA → stackout=00AA, underflow still 1.
  - clear → count=0, underflow=0.
- Simultaneous push+pop:
  - With stack [5,9], push=pop=1, din=16'h0C0C → count=2, stackout=0C0C; pop → stackout=5.
  - From empty, push=pop=1, din=3 → count=1, stackout=3, underflow=1.
- Gating and reset priority:
  - enable=1 with push din=16'h7777 → count unchanged.
  - reset=1 together with push → count=0, all flags 0, stackout=0.
  - clear together with push → count=0.
